// File: rtl/sonar_trigger_if.sv
// Control and sensor-pin bundle for the sonar ranging sequencer.
// slave is the sequencer's view; master is the controller/sensor side.
interface sonar_trigger_if;
    logic enable;
    logic start;
    logic echo;
    logic trig;
    logic busy;
    logic done;
    logic timeout;

    modport slave  (input enable, start, echo, output trig, busy, done, timeout);
    modport master (output enable, start, echo, input trig, busy, done, timeout);
endinterface

// File: rtl/sonar_trigger.sv
// HC-SR04 ranging sequencer: trigger pulse, minimum measurement period,
// and echo watchdog so a missing or stuck echo ends the cycle with a timeout.
module sonar_trigger #(
    parameter int TRIG_US     = 10,
    parameter int PERIOD_US   = 60000,
    parameter int RISE_TO_US  = 2000,
    parameter int ECHO_MAX_US = 38000
) (
    input  logic            clk_1m,
    input  logic            rst_n,
    sonar_trigger_if.slave  bus
);
    localparam logic [15:0] TRIG_LAST   = 16'(TRIG_US - 1);
    localparam logic [15:0] RISE_LAST   = 16'(RISE_TO_US - 1);
    localparam logic [15:0] ECHO_LAST   = 16'(ECHO_MAX_US - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0] PERIOD_MAX  = 16'(PERIOD_US);

    typedef enum logic [2:0] {IDLE, TRIG, ARM, ECHO, HOLD} state_t;

    state_t      state, state_nx;
    logic        sync1, echo_s, echo_q;
    logic        rise, fall;
    logic [15:0] cyc, w;
    logic        hold_to, hold_to_nx;
    logic        trig_reg, busy_reg, done_reg, timeout_reg;

    assign rise = echo_s & ~echo_q;
    assign fall = ~echo_s & echo_q;

    always_comb begin
        state_nx   = state;
        hold_to_nx = hold_to;
        case (state)
            IDLE: if (bus.start | bus.enable) state_nx = TRIG;
            TRIG: if (w == TRIG_LAST) state_nx = ARM;
            ARM: begin
                if (rise) begin
                    state_nx = ECHO;
                end else if (w == RISE_LAST) begin
                    state_nx   = HOLD;
                    hold_to_nx = 1'b1;
                end
            end
            ECHO: begin
                if (fall) begin
                    state_nx   = HOLD;
                    hold_to_nx = 1'b0;
                end else if (w == ECHO_LAST) begin
                    state_nx   = HOLD;
                    hold_to_nx = 1'b1;
                end
            end
            // A high echo_s pins us here so a stuck sensor cannot be re-triggered.
            HOLD: if (cyc >= PERIOD_LAST && !echo_s) state_nx = bus.enable ? TRIG : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            echo_s      <= 1'b0;
            echo_q      <= 1'b0;
            cyc         <= '0;
            w           <= '0;
            hold_to     <= 1'b0;
            trig_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state   <= state_nx;
            sync1   <= bus.echo;
            echo_s  <= sync1;
            echo_q  <= echo_s;
            hold_to <= hold_to_nx;
            // w saturates so a long stuck-echo HOLD cannot wrap back to w==0.
            if (state_nx != state)   w <= '0;
            else if (w != 16'hFFFF)  w <= w + 16'd1;
            if (state_nx == TRIG && state != TRIG) cyc <= '0;
            else if (cyc < PERIOD_MAX)             cyc <= cyc + 16'd1;
            trig_reg <= (state == TRIG);
            busy_reg <= (state != IDLE);
            done_reg <= (state == HOLD) && (w == '0);
            if (state == HOLD && w == '0) timeout_reg <= hold_to;
        end
    end

    assign bus.trig    = trig_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.timeout = timeout_reg;
endmodule

// File: tb/tb_sonar_trigger.sv
// Directed bench for sonar_trigger with scaled timing parameters.
// ec counts rising edges; values are sampled 1 ns after each edge.
module tb_sonar_trigger;
    localparam int TRIG = 10;
    localparam int P    = 1000;
    localparam int RTO  = 200;
    localparam int EMAX = 380;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sonar_trigger_if bus();

    sonar_trigger #(.TRIG_US(TRIG), .PERIOD_US(P), .RISE_TO_US(RTO), .ECHO_MAX_US(EMAX)) dut (
        .clk_1m(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int ec = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0, last_done = -1, rise_cnt = 0, last_rise = -1;
    logic trig_q = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= bus.trig;
            if (bus.trig && !trig_q) begin
                rise_cnt  <= rise_cnt + 1;
                last_rise <= ec;
            end
            if (bus.done) begin
                done_cnt  <= done_cnt + 1;
                last_done <= ec;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1; ec++;
    endtask

    task automatic run_to(input int x);
        while (ec < x) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.start = 1'b0; bus.echo = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.trig !== 1'b0)    begin errors++; $display("FAIL reset_trig got %b want 0", bus.trig); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        int n, f, d0, r0;
        d0 = done_cnt; r0 = rise_cnt;
        pulse_start(); n = ec;
        checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL single_trig_at_n got %b want 0", bus.trig); end
        tick();
        checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL single_trig_first got %b want 1", bus.trig); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_first got %b want 1", bus.busy); end
        run_to(n + TRIG);
        checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL single_trig_last got %b want 1", bus.trig); end
        tick();
        checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL single_trig_end got %b want 0", bus.trig); end
        run_to(n + 60); bus.echo = 1'b1;
        f = n + 118;
        run_to(f); bus.echo = 1'b0;
        run_to(f + 3);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_early got %b want 0", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", bus.done); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got %b want 0", bus.timeout); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b want 0", bus.done); end
        run_to(n + P);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", bus.busy); end
        run_to(n + P + 30);
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL single_trig_count got %0d want 1", rise_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_no_echo();
        int n, n2, r0;
        r0 = rise_cnt;
        pulse_start(); n = ec;
        run_to(n + TRIG + RTO);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL noecho_done_early got %b want 0", bus.done); end
        tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL noecho_done got %b want 1", bus.done); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL noecho_timeout got %b want 1", bus.timeout); end
        run_to(n + P - 10); pulse_start();
        run_to(n + P + 1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL noecho_busy got %b want 0", bus.busy); end
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL noecho_trig_count got %0d want 1", rise_cnt - r0); end
        pulse_start(); n2 = ec;
        tick();
        checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL noecho_retrig got %b want 1", bus.trig); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL noecho_timeout_held got %b want 1", bus.timeout); end
        run_to(n2 + P + 2);
    endtask

    task automatic test_reset_mid();
        int n, r0;
        pulse_start(); n = ec;
        run_to(n + 4);
        checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL rstmid_trig_pre got %b want 1", bus.trig); end
        rst_n = 1'b0; #1;
        checks++; if (bus.trig !== 1'b0)    begin errors++; $display("FAIL rstmid_trig got %b want 0", bus.trig); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got %b want 0", bus.timeout); end
        tick(); tick();
        rst_n = 1'b1;
        r0 = rise_cnt;
        run_to(ec + 50);
        checks++; if (rise_cnt !== r0)   begin errors++; $display("FAIL rstmid_idle_trig got %0d want %0d", rise_cnt, r0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy got %b want 0", bus.busy); end
        pulse_start(); n = ec;
        tick();
        checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL rstmid_restart got %b want 1", bus.trig); end
        run_to(n + P + 2);
    endtask

    task automatic test_start_ignored();
        int n, d0, r0;
        d0 = done_cnt; r0 = rise_cnt;
        pulse_start(); n = ec;
        // start during TRIG, plus an echo blip whose edges land in TRIG
        run_to(n + 2); bus.echo = 1'b1;
        tick(); bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(); bus.echo = 1'b0;
        run_to(n + 49); pulse_start();
        run_to(n + 230); pulse_start();
        run_to(n + P);
        checks++; if (last_done !== n + TRIG + RTO + 1) begin errors++; $display("FAIL ign_done_time got %0d want %0d", last_done, n + TRIG + RTO + 1); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL ign_timeout got %b want 1", bus.timeout); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy_hold got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_fall got %b want 0", bus.busy); end
        run_to(n + P + 20);
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL ign_trig_count got %0d want 1", rise_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stuck();
        int n, r, f, n2, r0;
        r0 = rise_cnt;
        bus.enable = 1'b1; tick(); n = ec;
        r = n + 51;
        run_to(r); bus.echo = 1'b1;
        run_to(r + 4 + EMAX + 2);
        checks++; if (last_done !== r + 4 + EMAX) begin errors++; $display("FAIL stuck_done_time got %0d want %0d", last_done, r + 4 + EMAX); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL stuck_timeout got %b want 1", bus.timeout); end
        f = r + 1500;
        run_to(f); bus.echo = 1'b0;
        checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL stuck_blocked got %0d want 1", rise_cnt - r0); end
        run_to(f + 5);
        bus.enable = 1'b0;
        checks++; if (last_rise !== f + 4) begin errors++; $display("FAIL stuck_retrig_time got %0d want %0d", last_rise, f + 4); end
        n2 = f + 3;
        run_to(n2 + P + 20);
        checks++; if (last_done !== n2 + TRIG + RTO + 1) begin errors++; $display("FAIL stuck_second_done got %0d want %0d", last_done, n2 + TRIG + RTO + 1); end
        checks++; if (rise_cnt - r0 !== 2) begin errors++; $display("FAIL stuck_trig_count got %0d want 2", rise_cnt - r0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stuck_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_free_run();
        int n, t, d0, r0;
        d0 = done_cnt; r0 = rise_cnt;
        bus.enable = 1'b1; tick(); n = ec;
        for (int k = 0; k < 2; k++) begin
            t = n + 1 + k * P;
            run_to(t + 1);
            checks++; if (last_rise !== t) begin errors++; $display("FAIL free_rise_%0d got %0d want %0d", k, last_rise, t); end
            run_to(t + 30); bus.echo = 1'b1;
            run_to(t + 88); bus.echo = 1'b0;
            run_to(t + 100);
            checks++; if (last_done !== t + 92) begin errors++; $display("FAIL free_done_%0d got %0d want %0d", k, last_done, t + 92); end
            checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL free_timeout_%0d got %b want 0", k, bus.timeout); end
        end
        run_to(n + P + 500); bus.enable = 1'b0;
        run_to(n + 2 * P);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL free_busy_hold got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL free_busy_fall got %b want 0", bus.busy); end
        checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL free_no_third_trig got %b want 0", bus.trig); end
        run_to(n + 2 * P + 20);
        checks++; if (rise_cnt - r0 !== 2) begin errors++; $display("FAIL free_trig_count got %0d want 2", rise_cnt - r0); end
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL free_done_count got %0d want 2", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_echo();
        test_reset_mid();
        test_start_ignored();
        test_stuck();
        test_free_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
